// File: rtl/la_capture_core.sv
`default_nettype none
// ============================================================================
// Module   : la_capture_core
// Purpose  : Logic-analyser capture engine. Synchronises the probe inputs,
//            samples them at a programmable rate into a circular buffer, and
//            keeps PRE_TRIG samples before a trigger and the rest after it.
//            Readout is rotated so that index 0 is always the oldest sample.
// Ports    : clk, reset (async, active-high)
//            probe, chan_enable             - probe data and per-channel gate
//            arm, abort                     - capture control
//            trig_mode/trig_mask/trig_value - trigger setup, used live
//            sample_div                     - one sample every sample_div+1 clks
//            rd_addr -> rd_data             - registered readout, 1 clk latency
//            state, done                    - status
// Revision : 1.0 - initial release
// ============================================================================
module la_capture_core #(
    parameter int CHANNEL_COUNT = 10,
    parameter int DEPTH         = 640,
    parameter int PRE_TRIG      = 64,
    parameter int DIV_W         = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [CHANNEL_COUNT-1:0]   probe,
    input  logic [CHANNEL_COUNT-1:0]   chan_enable,
    input  logic                       arm,
    input  logic                       abort,
    input  logic [1:0]                 trig_mode,
    input  logic [CHANNEL_COUNT-1:0]   trig_mask,
    input  logic [CHANNEL_COUNT-1:0]   trig_value,
    input  logic [DIV_W-1:0]           sample_div,
    input  logic [$clog2(DEPTH)-1:0]   rd_addr,
    output logic [CHANNEL_COUNT-1:0]   rd_data,
    output logic [2:0]                 state,
    output logic                       done
);

    localparam int AW       = $clog2(DEPTH);
    localparam int POST_LEN = DEPTH - PRE_TRIG - 1;

    localparam logic [AW-1:0] C_PTR_LAST  = AW'(DEPTH - 1);
    localparam logic [AW-1:0] C_PRE_LAST  = AW'((PRE_TRIG > 0) ? PRE_TRIG - 1 : 0);
    localparam logic [AW-1:0] C_POST_LAST = AW'((POST_LEN > 0) ? POST_LEN - 1 : 0);
    localparam logic [AW:0]   C_DEPTH_X   = (AW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_WAIT = 3'd2,
        ST_POST = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    state_t                     state_q, state_d;
    logic                       done_q, done_d;
    logic [CHANNEL_COUNT-1:0]   sync1_q, sync1_d, sync2_q, sync2_d;
    logic [AW-1:0]              wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]              base_q, base_d;
    logic [AW-1:0]              cnt_q, cnt_d;
    logic [DIV_W-1:0]           div_q, div_d;
    logic [CHANNEL_COUNT-1:0]   prev_q, prev_d;
    logic                       first_q, first_d;
    logic [CHANNEL_COUNT-1:0]   rd_data_q, rd_data_d;

    logic [CHANNEL_COUNT-1:0]   mem [DEPTH];

    logic [CHANNEL_COUNT-1:0]   sample;
    logic                       capturing;
    logic                       strobe;
    logic                       trig_hit;
    logic [AW-1:0]              wr_ptr_inc;
    logic [AW:0]                rd_sum;
    logic [AW:0]                rd_idx;

    // ------------------------------------------------------------------
    // Sampling datapath
    // ------------------------------------------------------------------
    always_comb begin
        sync1_d    = probe;
        sync2_d    = sync1_q;
        sample     = sync2_q & chan_enable;
        capturing  = (state_q == ST_PRE) || (state_q == ST_WAIT) || (state_q == ST_POST);
        strobe     = capturing && (div_q == sample_div);
        wr_ptr_inc = (wr_ptr_q == C_PTR_LAST) ? '0 : wr_ptr_q + AW'(1);
    end

    // Edge modes are suppressed on the first strobe after arm, because prev
    // still holds a sample from an earlier capture at that point.
    always_comb begin
        trig_hit = 1'b0;
        case (trig_mode)
            2'd0:    trig_hit = 1'b1;
            2'd1:    trig_hit = ((sample ^ trig_value) & trig_mask) == '0;
            2'd2:    trig_hit = !first_q && (|(~prev_q & sample & trig_mask));
            default: trig_hit = !first_q && (|(prev_q & ~sample & trig_mask));
        endcase
    end

    // ------------------------------------------------------------------
    // Control FSM: next state and register updates
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        done_d   = done_q;
        wr_ptr_d = wr_ptr_q;
        base_d   = base_q;
        cnt_d    = cnt_q;
        div_d    = div_q;
        prev_d   = prev_q;
        first_d  = first_q;

        if (capturing) begin
            div_d = strobe ? '0 : div_q + DIV_W'(1);
        end

        if (strobe) begin
            wr_ptr_d = wr_ptr_inc;
            prev_d   = sample;
            first_d  = 1'b0;
            cnt_d    = cnt_q + AW'(1);
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (arm) begin
                    state_d  = (PRE_TRIG > 0) ? ST_PRE : ST_WAIT;
                    done_d   = 1'b0;
                    wr_ptr_d = '0;
                    cnt_d    = '0;
                    div_d    = '0;
                    first_d  = 1'b1;
                end
            end
            ST_PRE: begin
                if (strobe && (cnt_q == C_PRE_LAST)) begin
                    state_d = ST_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_WAIT: begin
                if (strobe && trig_hit) begin
                    cnt_d = '0;
                    if (POST_LEN == 0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        base_d  = wr_ptr_inc;
                    end else begin
                        state_d = ST_POST;
                    end
                end
            end
            ST_POST: begin
                // The slot after the final write is the oldest sample held.
                if (strobe && (cnt_q == C_POST_LAST)) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    base_d  = wr_ptr_inc;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (abort) begin
            state_d = ST_IDLE;
            done_d  = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Readout: rotate by base so index 0 is the oldest sample
    // ------------------------------------------------------------------
    always_comb begin
        rd_sum    = {1'b0, base_q} + {1'b0, rd_addr};
        rd_idx    = (rd_sum >= C_DEPTH_X) ? rd_sum - C_DEPTH_X : rd_sum;
        rd_data_d = '0;
        if ({1'b0, rd_addr} < C_DEPTH_X) begin
            rd_data_d = mem[rd_idx[AW-1:0]];
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            done_q    <= 1'b0;
            sync1_q   <= '0;
            sync2_q   <= '0;
            wr_ptr_q  <= '0;
            base_q    <= '0;
            cnt_q     <= '0;
            div_q     <= '0;
            prev_q    <= '0;
            first_q   <= 1'b0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            done_q    <= done_d;
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            wr_ptr_q  <= wr_ptr_d;
            base_q    <= base_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            prev_q    <= prev_d;
            first_q   <= first_d;
            rd_data_q <= rd_data_d;
        end
    end

    // Sample memory carries no reset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (strobe) begin
            mem[wr_ptr_q] <= sample;
        end
    end

    assign rd_data = rd_data_q;
    assign state   = state_q;
    assign done    = done_q;

endmodule
`default_nettype wire

// File: tb/tb_la_capture_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_la_capture_core
// Purpose  : Self-checking bench for la_capture_core. A queue-based model
//            records every sample taken since arm, locates the trigger from
//            the trigger rules, and derives state/done and the readout window.
// Revision : 1.0 - initial release
// ============================================================================
module tb_la_capture_core;

    localparam int CH       = 10;
    localparam int DEPTH    = 640;
    localparam int PRE_TRIG = 64;
    localparam int DIV_W    = 16;
    localparam int AW       = $clog2(DEPTH);
    localparam int POST_LEN = DEPTH - PRE_TRIG - 1;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [CH-1:0]    probe = '0;
    logic [CH-1:0]    chan_enable = '1;
    logic             arm = 1'b0;
    logic             abort = 1'b0;
    logic [1:0]       trig_mode = 2'd0;
    logic [CH-1:0]    trig_mask = '0;
    logic [CH-1:0]    trig_value = '0;
    logic [DIV_W-1:0] sample_div = '0;
    logic [AW-1:0]    rd_addr = '0;
    logic [CH-1:0]    rd_data;
    logic [2:0]       state;
    logic             done;

    la_capture_core #(
        .CHANNEL_COUNT (CH),
        .DEPTH         (DEPTH),
        .PRE_TRIG      (PRE_TRIG),
        .DIV_W         (DIV_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .probe       (probe),
        .chan_enable (chan_enable),
        .arm         (arm),
        .abort       (abort),
        .trig_mode   (trig_mode),
        .trig_mask   (trig_mask),
        .trig_value  (trig_value),
        .sample_div  (sample_div),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .state       (state),
        .done        (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;
    logic [CH-1:0] rand_mask = '0;

    // ------------------------------------------------------------------
    // Behavioural model: list of samples since arm plus trigger position
    // ------------------------------------------------------------------
    logic [CH-1:0] m_s1 = '0, m_s2 = '0;
    logic [CH-1:0] m_samples[$];
    bit            m_active = 1'b0;
    bit            m_done   = 1'b0;
    int            m_trig   = -1;
    int            m_phase  = 0;

    function automatic logic [2:0] exp_state();
        if (!m_active) return m_done ? 3'd4 : 3'd0;
        if (m_samples.size() < PRE_TRIG) return 3'd1;
        if (m_trig < 0) return 3'd2;
        return 3'd3;
    endfunction

    task automatic model_sample(input logic [CH-1:0] samp);
        int idx;
        bit hit;
        logic [CH-1:0] prv;
        idx = m_samples.size();
        m_samples.push_back(samp);
        if (m_trig < 0 && idx >= PRE_TRIG) begin
            prv = (idx > 0) ? m_samples[idx-1] : '0;
            case (trig_mode)
                2'd0: hit = 1'b1;
                2'd1: hit = ((samp & trig_mask) == (trig_value & trig_mask));
                2'd2: hit = (idx > 0) && ((~prv & samp & trig_mask) != '0);
                default: hit = (idx > 0) && ((prv & ~samp & trig_mask) != '0);
            endcase
            if (hit) m_trig = idx;
        end
        if (m_trig >= 0 && idx == m_trig + POST_LEN) begin
            m_active = 1'b0;
            m_done   = 1'b1;
        end
    endtask

    task automatic model_step();
        logic [CH-1:0] samp;
        if (reset) begin
            m_s1 = '0; m_s2 = '0; m_active = 1'b0; m_done = 1'b0;
            m_trig = -1; m_phase = 0; m_samples.delete();
        end else begin
            samp = m_s2 & chan_enable;
            if (abort) begin
                m_active = 1'b0;
                m_done   = 1'b0;
            end else if (m_active) begin
                if (m_phase == int'(sample_div)) begin
                    m_phase = 0;
                    model_sample(samp);
                end else begin
                    m_phase++;
                end
            end else if (arm) begin
                m_active = 1'b1;
                m_done   = 1'b0;
                m_phase  = 0;
                m_trig   = -1;
                m_samples.delete();
            end
            m_s2 = m_s1;
            m_s1 = probe;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge reset);
            model_step();
        end
    end

    // ------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    always @(negedge clk) begin
        if (cmp_en && !reset) begin
            check("state", {29'd0, state}, {29'd0, exp_state()});
            check("done", {31'd0, done}, {31'd0, m_done});
        end
    end

    task automatic tick();
        @(negedge clk);
        probe = (probe & ~rand_mask) | (CH'($urandom) & rand_mask);
    endtask

    task automatic do_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int n = 0;
        while (!m_done && n < budget) begin
            tick();
            n++;
        end
        if (!m_done) fail_now(name);
    endtask

    // Clocks from the arm edge until done is seen, compared with a literal.
    task automatic count_to_done(input int budget, input int exp_clks, input string name);
        int n = 0;
        while (!done && n < budget) begin
            tick();
            n++;
        end
        check(name, n, exp_clks);
    endtask

    task automatic readout(input bit bit0_zero);
        int start;
        if (!m_done) return;
        start = m_trig - PRE_TRIG;
        for (int k = 0; k < DEPTH; k++) begin
            rd_addr = AW'(k);
            tick();
            check("rd_data", {22'd0, rd_data}, {22'd0, m_samples[start+k]});
            if (bit0_zero) check("disabled_bit0", {31'd0, rd_data[0]}, 32'd0);
        end
        rd_addr = AW'(700);
        tick();
        check("rd_out_of_range_700", {22'd0, rd_data}, 32'd0);
        rd_addr = '1;
        tick();
        check("rd_out_of_range_max", {22'd0, rd_data}, 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        #1;
        check("reset_state", {29'd0, state}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_rd_data", {22'd0, rd_data}, 32'd0);
        repeat (3) tick();
        reset  = 1'b0;
        cmp_en = 1'b1;
        tick();

        // Immediate trigger: exactly DEPTH strobes at one sample per clock.
        rand_mask = '1;
        trig_mode = 2'd0;
        do_arm();
        count_to_done(5000, 640, "done_latency_div0");
        readout(1'b0);

        // Divider of 3: strobes every 4 clocks.
        sample_div = 16'd3;
        do_arm();
        count_to_done(10000, 2560, "done_latency_div3");
        readout(1'b0);
        sample_div = '0;

        // Rising edge on ch3 long after the buffer has wrapped.
        probe      = '0;
        rand_mask  = 10'h3F7;
        trig_mode  = 2'd2;
        trig_mask  = 10'h008;
        do_arm();
        repeat (2000) tick();
        probe[3] = 1'b1;
        wait_done(2000, "wait_rise_ch3");
        if (m_done) check("post_strobes", m_samples.size() - m_trig - 1, 575);
        readout(1'b0);
        rd_addr = AW'(63);
        tick();
        check("idx63_ch3", {31'd0, rd_data[3]}, 32'd0);
        rd_addr = AW'(64);
        tick();
        check("idx64_ch3", {31'd0, rd_data[3]}, 32'd1);

        // Abort during POST, then a clean re-arm.
        rand_mask = '1;
        trig_mode = 2'd0;
        do_arm();
        for (int n = 0; n < 2000 && exp_state() != 3'd3; n++) tick();
        if (exp_state() != 3'd3) fail_now("reach_post");
        repeat (10) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_state", {29'd0, state}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        do_arm();
        wait_done(2000, "rearm_after_abort");
        readout(1'b0);

        // Disabled channel 0 with probe0 held high.
        chan_enable = 10'h3FE;
        rand_mask   = 10'h3FE;
        probe[0]    = 1'b1;
        do_arm();
        wait_done(2000, "chan_disable_capture");
        readout(1'b1);
        chan_enable = '1;
        rand_mask   = '1;

        // Falling edge with empty mask never fires.
        trig_mode = 2'd3;
        trig_mask = '0;
        do_arm();
        repeat (10000) tick();
        check("no_trigger_wait", {29'd0, state}, 32'd2);
        abort = 1'b1;
        tick();
        abort = 1'b0;

        // Level match with empty mask fires on the first WAIT strobe.
        trig_mode  = 2'd1;
        trig_mask  = '0;
        trig_value = CH'($urandom);
        do_arm();
        wait_done(2000, "level_mask0");
        check("level_mask0_trig_idx", m_trig, PRE_TRIG);
        readout(1'b0);

        // Randomised captures.
        for (int t = 0; t < 4; t++) begin
            trig_mode   = 2'($urandom_range(0, 3));
            trig_mask   = (CH'(1) << $urandom_range(0, CH-1)) | (CH'(1) << $urandom_range(0, CH-1));
            trig_value  = CH'($urandom);
            chan_enable = CH'($urandom) | trig_mask;
            sample_div  = DIV_W'($urandom_range(0, 2));
            do_arm();
            wait_done(20000, "random_capture");
            readout(1'b0);
        end
        chan_enable = '1;
        sample_div  = '0;

        // Asynchronous reset in the middle of WAIT.
        trig_mode = 2'd3;
        trig_mask = '0;
        rd_addr   = AW'(5);
        do_arm();
        repeat (200) tick();
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_state", {29'd0, state}, 32'd0);
        check("async_reset_done", {31'd0, done}, 32'd0);
        check("async_reset_rd_data", {22'd0, rd_data}, 32'd0);
        repeat (2) tick();
        reset = 1'b0;
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/la_capture_core.md
LA_CAPTURE_CORE -- requirements
Module: la_capture_core

Interface
REQ-001 SHALL have parameter CHANNEL_COUNT, default 10, number of probe channels.
REQ-002 SHALL have parameter DEPTH, default 640, samples stored per capture (one per display column).
REQ-003 SHALL have parameter PRE_TRIG, default 64, samples retained before the trigger (0 <= PRE_TRIG < DEPTH).
REQ-004 SHALL have parameter DIV_W, default 16, width of sample_div.
REQ-005 SHALL have port clk  input  1  clock.
REQ-006 SHALL have port reset  input  1  asynchronous reset, active-high.
REQ-007 SHALL have port probe  input  CHANNEL_COUNT  asynchronous probe inputs.
REQ-008 SHALL have port chan_enable  input  CHANNEL_COUNT  per-channel enable; disabled channels are stored as 0.
REQ-009 SHALL have port arm  input  1  start-capture pulse.
REQ-010 SHALL have port abort  input  1  cancel capture.
REQ-011 SHALL have port trig_mode  input  2  0 immediate, 1 level match, 2 rising edge, 3 falling edge.
REQ-012 SHALL have port trig_mask  input  CHANNEL_COUNT  channels participating in trigger.
REQ-013 SHALL have port trig_value  input  CHANNEL_COUNT  level-match pattern.
REQ-014 SHALL have port sample_div  input  DIV_W  one sample every sample_div+1 clocks.
REQ-015 SHALL have port rd_addr  input  clog2(DEPTH)  readout index, 0 = oldest sample.
REQ-016 SHALL have port rd_data  output  CHANNEL_COUNT  sample at rd_addr.
REQ-017 SHALL have port state  output  3  FSM state code.
REQ-018 SHALL have port done  output  1  capture complete.

Function
REQ-019 Probes SHALL pass a 2-flop synchronizer; sample s = sync_probe & chan_enable.
REQ-020 Divider counter SHALL count 0..sample_div, clear on arm, and pulse strobe when count == sample_div; only counts in states PRE/WAIT/POST.
REQ-021 Each strobe SHALL write s to mem[wr_ptr]; wr_ptr increments, wrapping DEPTH-1 -> 0 (explicit compare, DEPTH need not be a power of 2).
REQ-022 prev SHALL hold the previous strobe's s; trigger cond: mode0 true; mode1 (s&mask)==(value&mask); mode2 |(~prev & s & mask); mode3 |(prev & ~s & mask).
REQ-023 prev SHALL be loaded with the first sample after arm without evaluating edges on that strobe (no false edge).
REQ-024 States: IDLE=0, PRE=1, WAIT=2, POST=3, DONE=4.
REQ-025 IDLE/DONE + arm -> PRE (PRE_TRIG>0) or WAIT (PRE_TRIG=0); done cleared; wr_ptr, counters cleared.
REQ-026 PRE -> WAIT after PRE_TRIG strobes written.
REQ-027 WAIT: writes continue circularly; strobe with cond true writes that sample and -> POST (or DONE if DEPTH-PRE_TRIG-1 == 0).
REQ-028 POST -> DONE after DEPTH-PRE_TRIG-1 further strobes; on entry latch base = wr_ptr (next write slot = oldest sample); done=1.
REQ-029 Trigger sample SHALL read out at index PRE_TRIG.
REQ-030 rd_data SHALL be registered, valid one clock after rd_addr, = mem[(base+rd_addr) mod DEPTH]; rd_addr >= DEPTH returns 0.
REQ-031 arm while in PRE/WAIT/POST SHALL be ignored.
REQ-032 abort SHALL take priority over arm; any state -> IDLE next clock, done=0, memory contents kept.
REQ-033 mode2/3 with trig_mask=0 SHALL never trigger (WAIT indefinitely); mode1 with mask=0 triggers on first WAIT strobe.
REQ-034 Trigger inputs and sample_div SHALL be used live (not latched at arm).

Reset
REQ-035 reset SHALL force state=IDLE, done=0, rd_data=0, wr_ptr=0, base=0, divider=0, prev=0, synchronizer=0; memory contents undefined.

Verification
REQ-036 DEPTH=640, PRE_TRIG=64, div=0, mode0, arm -> done rises after exactly 640 strobes; index k reads the k-th sample written.
REQ-037 mode2 mask=0x008, ch3 rises 2000 clocks after arm (wr_ptr wrapped) -> index 63 ch3=0, index 64 ch3=1, done after 575 further strobes.
REQ-038 sample_div=3, mode0 -> strobes spaced 4 clocks; done about 2560 clocks after arm.
REQ-039 abort during POST -> state=0 next clock, done=0; re-arm completes a normal capture.
REQ-040 chan_enable bit0=0 with probe0 held 1 -> all samples bit0=0; mode3 mask=0 -> remains in WAIT 10000 clocks.
REQ-041 reset asserted mid-WAIT -> state=0, done=0, rd_data=0 immediately (asynchronous).
